// File: rtl/fixpoint_iter_engine.sv
// fixpoint_iter_engine: iterates a stage-chained propagation step to a fixpoint.
// Optional FIXPOINT_TRACE_EN adds trace_valid/trace_state update trace outputs.
module fixpoint_iter_engine #(
  parameter int N        = 9,
  parameter int MAX_ITER = 16,
  parameter int CNT_W    = $clog2(MAX_ITER + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [N-1:0]     init_state,
  input  logic [N-1:0]     block_mask,
  input  logic [N-1:0]     bad_mask,
  output logic             done_valid,
  input  logic             done_ready,
  output logic [N-1:0]     final_state,
  output logic [CNT_W-1:0] iter_count,
  output logic             converged,
  output logic             violation
`ifdef FIXPOINT_TRACE_EN
  ,
  output logic             trace_valid,
  output logic [N-1:0]     trace_state
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [N-1:0]     r_cur;
  logic [N-1:0]     r_blk;
  logic [N-1:0]     r_bad;
  logic [CNT_W-1:0] r_cnt;
  logic             r_conv;
  logic [N-1:0]     w_nxt;
  logic             w_fix;
  logic             w_cap;
  logic             w_accept;
  logic             w_upd;
  logic             w_finish;

  // Bit i picks up bit i-1 unless stage i is blocked; bit 0 only holds.
  assign w_nxt = r_cur | ((r_cur << 1) & ~r_blk);
  assign w_fix = (w_nxt == r_cur);
  assign w_cap = (r_cnt == CNT_W'(MAX_ITER));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state and step control; fixpoint test takes priority over abort.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_upd       = 1'b0;
    w_finish    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (w_fix || w_cap) begin
          w_finish    = 1'b1;
          w_state_nxt = S_DONE;
        end else begin
          w_upd = 1'b1;
        end
      end
      S_DONE: begin
        if (done_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Job registers: latch on accept, advance on each update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cur  <= '0;
      r_blk  <= '0;
      r_bad  <= '0;
      r_cnt  <= '0;
      r_conv <= 1'b0;
    end else begin
      if (w_accept) begin
        r_cur  <= init_state;
        r_blk  <= block_mask;
        r_bad  <= bad_mask;
        r_cnt  <= '0;
        r_conv <= 1'b0;
      end else if (w_upd) begin
        r_cur <= w_nxt;
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_finish) r_conv <= w_fix;
    end
  end

  assign start_ready = (r_state == S_IDLE);
  assign done_valid  = (r_state == S_DONE);
  assign final_state = r_cur;
  assign iter_count  = r_cnt;
  assign converged   = r_conv;
  assign violation   = |(r_cur & r_bad);

`ifdef FIXPOINT_TRACE_EN
  logic         r_tv;
  logic [N-1:0] r_ts;

  // One-cycle pulse after each update carrying the state just written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tv <= 1'b0;
      r_ts <= '0;
    end else begin
      r_tv <= w_upd;
      if (w_upd) r_ts <= w_nxt;
    end
  end

  assign trace_valid = r_tv;
  assign trace_state = r_ts;
`endif

endmodule

// File: tb/tb_fixpoint_iter_engine.sv
// tb_fixpoint_iter_engine: directed + random jobs on MAX_ITER=16 and 4 builds.
// Expectations come from a reachability/distance model of the propagation.
module tb_fixpoint_iter_engine;

  logic       clk;
  logic       rst_n;
  logic       start_valid;
  logic [8:0] init_state;
  logic [8:0] block_mask;
  logic [8:0] bad_mask;
  logic       done_ready;

  logic       sr0, dv0, cv0, vi0;
  logic [8:0] fs0;
  logic [4:0] ic0;
  logic       sr4, dv4, cv4, vi4;
  logic [8:0] fs4;
  logic [2:0] ic4;

  int nchk;
  int nfail;

  logic [8:0] e_fin  [2];
  int         e_cnt  [2];
  bit         e_conv [2];
  bit         e_viol [2];

`ifdef FIXPOINT_TRACE_EN
  logic       tv0, tv4;
  logic [8:0] ts0, ts4;
  int         tcnt;
  logic [8:0] tfirst;
  logic [8:0] tlast;
`endif

  fixpoint_iter_engine #(.N(9), .MAX_ITER(16)) u0 (
    .clk(clk), .rst_n(rst_n),
    .start_valid(start_valid), .start_ready(sr0),
    .init_state(init_state), .block_mask(block_mask),
    .bad_mask(bad_mask),
    .done_valid(dv0), .done_ready(done_ready),
    .final_state(fs0), .iter_count(ic0),
    .converged(cv0), .violation(vi0)
`ifdef FIXPOINT_TRACE_EN
    , .trace_valid(tv0), .trace_state(ts0)
`endif
  );

  fixpoint_iter_engine #(.N(9), .MAX_ITER(4)) u4 (
    .clk(clk), .rst_n(rst_n),
    .start_valid(start_valid), .start_ready(sr4),
    .init_state(init_state), .block_mask(block_mask),
    .bad_mask(bad_mask),
    .done_valid(dv4), .done_ready(done_ready),
    .final_state(fs4), .iter_count(ic4),
    .converged(cv4), .violation(vi4)
`ifdef FIXPOINT_TRACE_EN
    , .trace_valid(tv4), .trace_state(ts4)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Bit i ends up set iff some seed j<=i reaches it with no block on
  // stages j+1..i; it is set after i-j updates. Abort keeps only bits
  // reachable within maxit updates.
  task automatic model(input logic [8:0] ini, input logic [8:0] blk,
                       input logic [8:0] bad, input int maxit,
                       output logic [8:0] fin, output int cnt,
                       output bit conv, output bit viol);
    int d [9];
    int k;
    k = 0;
    for (int i = 0; i < 9; i++) begin
      d[i] = -1;
      for (int j = i; j >= 0; j--) begin
        if (ini[j]) begin
          d[i] = i - j;
          break;
        end
        if (blk[j]) break;
      end
      if (d[i] > k) k = d[i];
    end
    fin = '0;
    conv = (k <= maxit);
    cnt = conv ? k : maxit;
    for (int i = 0; i < 9; i++)
      fin[i] = (d[i] >= 0) && (d[i] <= cnt);
    viol = |(fin & bad);
  endtask

  // Whenever a result is presented it must match the model.
  always @(negedge clk) begin
    if (rst_n) begin
      if (dv0) begin
        chk("u0 final_state", 32'(fs0), 32'(e_fin[0]));
        chk("u0 iter_count", 32'(ic0), e_cnt[0]);
        chk("u0 converged", 32'(cv0), 32'(e_conv[0]));
        chk("u0 violation", 32'(vi0), 32'(e_viol[0]));
      end
      if (dv4) begin
        chk("u4 final_state", 32'(fs4), 32'(e_fin[1]));
        chk("u4 iter_count", 32'(ic4), e_cnt[1]);
        chk("u4 converged", 32'(cv4), 32'(e_conv[1]));
        chk("u4 violation", 32'(vi4), 32'(e_viol[1]));
      end
    end
  end

`ifdef FIXPOINT_TRACE_EN
  always @(negedge clk) begin
    if (tv0) begin
      if (tcnt == 0) tfirst = ts0;
      tlast = ts0;
      tcnt++;
    end
  end
`endif

  task automatic start_job(input logic [8:0] ini, input logic [8:0] blk,
                           input logic [8:0] bad,
                           output int l0, output int l4);
    bit seen0, seen4;
    int n;
    model(ini, blk, bad, 16, e_fin[0], e_cnt[0], e_conv[0], e_viol[0]);
    model(ini, blk, bad, 4, e_fin[1], e_cnt[1], e_conv[1], e_viol[1]);
    chk("u0 idle start_ready", 32'(sr0), 1);
    chk("u4 idle start_ready", 32'(sr4), 1);
    start_valid = 1'b1;
    init_state  = ini;
    block_mask  = blk;
    bad_mask    = bad;
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    init_state  = 9'($urandom);
    block_mask  = 9'($urandom);
    bad_mask    = 9'($urandom);
    seen0 = 1'b0;
    seen4 = 1'b0;
    l0 = 0;
    l4 = 0;
    n = 0;
    while (!(seen0 && seen4) && n < 40) begin
      chk("u0 busy start_ready", 32'(sr0), 0);
      chk("u4 busy start_ready", 32'(sr4), 0);
      if (!seen0 && dv0) begin
        seen0 = 1'b1;
        l0 = n;
      end
      if (!seen4 && dv4) begin
        seen4 = 1'b1;
        l4 = n;
      end
      if (!(seen0 && seen4)) begin
        @(posedge clk);
        #1;
        n++;
      end
    end
    chk("u0 latency", l0, e_cnt[0] + 1);
    chk("u4 latency", l4, e_cnt[1] + 1);
  endtask

  task automatic finish_job(input int hold);
    for (int h = 0; h < hold; h++) begin
      start_valid = 1'b1;
      init_state  = 9'($urandom);
      @(posedge clk);
      #1;
      chk("u0 hold done_valid", 32'(dv0), 1);
      chk("u4 hold done_valid", 32'(dv4), 1);
      chk("u0 hold start_ready", 32'(sr0), 0);
    end
    start_valid = 1'b0;
    done_ready  = 1'b1;
    @(posedge clk);
    #1;
    done_ready = 1'b0;
    chk("u0 post-handshake start_ready", 32'(sr0), 1);
    chk("u4 post-handshake start_ready", 32'(sr4), 1);
    chk("u0 post-handshake done_valid", 32'(dv0), 0);
    chk("u4 post-handshake done_valid", 32'(dv4), 0);
  endtask

  initial begin
    int l0, l4;
    logic [8:0] ri, rb, rd;
    nchk = 0;
    nfail = 0;
`ifdef FIXPOINT_TRACE_EN
    tcnt = 0;
    tfirst = '0;
    tlast = '0;
`endif
    rst_n = 1'b0;
    start_valid = 1'b0;
    init_state = '0;
    block_mask = '0;
    bad_mask = '0;
    done_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset start_ready", 32'(sr0), 1);
    chk("reset done_valid", 32'(dv0), 0);
    chk("reset final_state", 32'(fs0), 0);
    chk("reset iter_count", 32'(ic0), 0);
    chk("reset converged", 32'(cv0), 0);
    chk("reset violation", 32'(vi0), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Full chain; the MAX_ITER=4 build aborts after 4 updates.
    start_job(9'h001, 9'h000, 9'h000, l0, l4);
    chk("lit chain final", 32'(fs0), 32'h1FF);
    chk("lit chain count", 32'(ic0), 8);
    chk("lit chain conv", 32'(cv0), 1);
    chk("lit chain viol", 32'(vi0), 0);
    chk("lit chain latency", l0, 9);
    chk("lit abort final", 32'(fs4), 32'h01F);
    chk("lit abort count", 32'(ic4), 4);
    chk("lit abort conv", 32'(cv4), 0);
    chk("lit abort latency", l4, 5);
    finish_job(1);
`ifdef FIXPOINT_TRACE_EN
    chk("trace pulses", tcnt, 8);
    chk("trace first", 32'(tfirst), 32'h003);
    chk("trace last", 32'(tlast), 32'h1FF);
`endif

    start_job(9'h001, 9'h010, 9'h100, l0, l4);
    chk("lit block final", 32'(fs0), 32'h00F);
    chk("lit block count", 32'(ic0), 3);
    chk("lit block conv", 32'(cv0), 1);
    chk("lit block viol", 32'(vi0), 0);
    finish_job(0);

    start_job(9'h000, 9'h000, 9'h000, l0, l4);
    chk("lit zero final", 32'(fs0), 0);
    chk("lit zero count", 32'(ic0), 0);
    chk("lit zero conv", 32'(cv0), 1);
    chk("lit zero latency", l0, 1);
    finish_job(0);

    start_job(9'h1FF, 9'h000, 9'h000, l0, l4);
    chk("lit full final", 32'(fs0), 32'h1FF);
    chk("lit full count", 32'(ic0), 0);
    chk("lit full latency", l0, 1);
    finish_job(0);

    // Violation with a long done_ready stall and ignored start requests.
    start_job(9'h001, 9'h000, 9'h100, l0, l4);
    chk("lit viol", 32'(vi0), 1);
    finish_job(5);

    // done_ready without a result does nothing.
    done_ready = 1'b1;
    @(posedge clk);
    #1;
    done_ready = 1'b0;
    chk("stray done_ready start_ready", 32'(sr0), 1);
    chk("stray done_ready done_valid", 32'(dv0), 0);

    // Reset in the middle of a run.
    start_valid = 1'b1;
    init_state = 9'h001;
    block_mask = 9'h000;
    bad_mask = 9'h1FF;
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("mid-run reset done_valid", 32'(dv0), 0);
    chk("mid-run reset start_ready", 32'(sr0), 1);
    chk("mid-run reset final_state", 32'(fs0), 0);
    chk("mid-run reset iter_count", 32'(ic0), 0);
    chk("mid-run reset violation", 32'(vi0), 0);
    chk("mid-run reset u4 final_state", 32'(fs4), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    start_job(9'h003, 9'h000, 9'h080, l0, l4);
    finish_job(0);

    for (int t = 0; t < 40; t++) begin
      ri = 9'($urandom & $urandom & $urandom);
      rb = 9'($urandom & $urandom);
      rd = 9'($urandom);
      start_job(ri, rb, rd, l0, l4);
      finish_job(int'($urandom_range(0, 2)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             nchk, nfail);
    $finish;
  end

endmodule
